// File: rtl/fetch_queue_2way.sv
// Two-wide instruction fetch unit: owns the fetch PC and buffers instruction pairs for decode.
// Optional macro FETCH_BR_SPLIT_EN: predecode slot 1 and end the pair after a control transfer.
module fetch_queue_2way #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             redirect_en,
    input  logic [63:0]      redirect_pc,
    output logic [63:0]      imem_pc,
    output logic [63:0]      imem_pc4,
    input  logic [31:0]      imem_instr1,
    input  logic [31:0]      imem_instr2,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [63:0]      dec_pc,
    output logic [31:0]      dec_instr1,
    output logic [31:0]      dec_instr2,
    output logic             dec_valid2,
    output logic [CNT_W-1:0] q_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [63:0]      fetch_pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [63:0] q_pc     [DEPTH];
    logic [31:0] q_instr1 [DEPTH];
    logic [31:0] q_instr2 [DEPTH];
    logic        q_v2     [DEPTH];

    logic        pop;
    logic        push;
    logic        not_empty;
    logic        new_v2;
    logic [63:0] pc_step;

    assign imem_pc  = fetch_pc;
    assign imem_pc4 = fetch_pc + 64'd4;

    assign not_empty = (count != '0);
    assign pop       = not_empty && dec_ready;
    // A full queue still accepts a pair when decode frees the head in the same cycle.
    assign push      = !redirect_en && ((count < CNT_W'(DEPTH)) || pop);

`ifdef FETCH_BR_SPLIT_EN
    logic is_ctrl;
    assign is_ctrl = (imem_instr1[6:0] == 7'h63) ||
                     (imem_instr1[6:0] == 7'h67) ||
                     (imem_instr1[6:0] == 7'h6F);
    assign new_v2  = !is_ctrl;
    assign pc_step = is_ctrl ? 64'd4 : 64'd8;
`else
    assign new_v2  = 1'b1;
    assign pc_step = 64'd8;
`endif

    assign dec_valid  = not_empty;
    assign q_count    = count;
    assign dec_pc     = not_empty ? q_pc[rd_ptr]     : 64'h0;
    assign dec_instr1 = not_empty ? q_instr1[rd_ptr] : 32'h0;
    assign dec_instr2 = not_empty ? q_instr2[rd_ptr] : 32'h0;
    assign dec_valid2 = not_empty ? q_v2[rd_ptr]     : 1'b0;

    // Reset outranks redirect; redirect discards any pop and blocks the push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect_en) begin
            fetch_pc <= redirect_pc & ~64'h3;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + pc_step;
                wr_ptr   <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            q_pc[wr_ptr]     <= fetch_pc;
            q_instr1[wr_ptr] <= imem_instr1;
            q_instr2[wr_ptr] <= imem_instr2;
            q_v2[wr_ptr]     <= new_v2;
        end
    end

endmodule

// File: tb/tb_fetch_queue_2way.sv
// Directed self-checking bench for fetch_queue_2way with a small combinational instruction memory.
// Expectations for the split feature follow FETCH_BR_SPLIT_EN as seen by this compile.
module tb_fetch_queue_2way;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             redirect_en;
    logic [63:0]      redirect_pc;
    logic [63:0]      imem_pc;
    logic [63:0]      imem_pc4;
    logic [31:0]      imem_instr1;
    logic [31:0]      imem_instr2;
    logic             dec_valid;
    logic             dec_ready;
    logic [63:0]      dec_pc;
    logic [31:0]      dec_instr1;
    logic [31:0]      dec_instr2;
    logic             dec_valid2;
    logic [CNT_W-1:0] q_count;

    int checks = 0;
    int errors = 0;

    fetch_queue_2way #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .imem_pc     (imem_pc),
        .imem_pc4    (imem_pc4),
        .imem_instr1 (imem_instr1),
        .imem_instr2 (imem_instr2),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_pc      (dec_pc),
        .dec_instr1  (dec_instr1),
        .dec_instr2  (dec_instr2),
        .dec_valid2  (dec_valid2),
        .q_count     (q_count)
    );

    always #5 clk = ~clk;

    // Known words at the addresses the tests name; elsewhere an addi-like word encoding the address.
    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        case (addr)
            64'h00:  mem_word = 32'h015A04B3;
            64'h04:  mem_word = 32'h00148493;
            64'h2C:  mem_word = 32'h02728463;
            64'h54:  mem_word = 32'h014AEA13;
            default: mem_word = {addr[24:0], 7'h13};
        endcase
    endfunction

    assign imem_instr1 = mem_word(imem_pc);
    assign imem_instr2 = mem_word(imem_pc4);

    task automatic check_value(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 64'h0;
        dec_ready   = 1'b1;
        step();
        step();

        // Reset state and first fetch
        check_value("rst_count", 64'(q_count), 64'd0);
        check_value("rst_valid", 64'(dec_valid), 64'd0);
        check_value("rst_valid2", 64'(dec_valid2), 64'd0);
        check_value("rst_dec_pc", dec_pc, 64'h0);
        check_value("rst_instr1", 64'(dec_instr1), 64'h0);
        check_value("rst_instr2", 64'(dec_instr2), 64'h0);
        rst_n = 1'b1;
        check_value("t1_imem_pc", imem_pc, 64'h0);
        check_value("t1_imem_pc4", imem_pc4, 64'h4);
        step();
        check_value("t1_valid", 64'(dec_valid), 64'd1);
        check_value("t1_dec_pc", dec_pc, 64'h0);
        check_value("t1_instr1", 64'(dec_instr1), 64'h015A04B3);
        check_value("t1_instr2", 64'(dec_instr2), 64'h00148493);
        check_value("t1_valid2", 64'(dec_valid2), 64'd1);
        check_value("t1_count", 64'(q_count), 64'd1);
        step();
        check_value("t1_dec_pc_8", dec_pc, 64'h8);
        check_value("t1_count_steady", 64'(q_count), 64'd1);
        step();
        check_value("t1_dec_pc_10", dec_pc, 64'h10);

        // Fill with decode stalled, then stream while full
        rst_n     = 1'b0;
        dec_ready = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            step();
            check_value("t2_fill_count", 64'(q_count), 64'(i));
        end
        check_value("t2_full_imem_pc", imem_pc, 64'h20);
        step();
        check_value("t2_hold_count", 64'(q_count), 64'd4);
        check_value("t2_hold_imem_pc", imem_pc, 64'h20);
        check_value("t2_head_pc", dec_pc, 64'h0);
        dec_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            check_value("t2_stream_count", 64'(q_count), 64'd4);
            check_value("t2_stream_pc", dec_pc, 64'(i * 8));
        end
        check_value("t2_stream_imem_pc", imem_pc, 64'h50);

        // Redirect while full, unaligned target
        dec_ready   = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 64'h56;
        step();
        redirect_en = 1'b0;
        check_value("t3_count", 64'(q_count), 64'd0);
        check_value("t3_valid", 64'(dec_valid), 64'd0);
        check_value("t3_imem_pc", imem_pc, 64'h54);
        check_value("t3_empty_pc", dec_pc, 64'h0);
        step();
        check_value("t3_dec_pc", dec_pc, 64'h54);
        check_value("t3_instr1", 64'(dec_instr1), 64'h014AEA13);
        check_value("t3_count1", 64'(q_count), 64'd1);

        // Redirect together with a pop at count 2
        step();
        check_value("t4_count2", 64'(q_count), 64'd2);
        dec_ready   = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 64'h100;
        step();
        redirect_en = 1'b0;
        check_value("t4_count", 64'(q_count), 64'd0);
        check_value("t4_valid", 64'(dec_valid), 64'd0);
        check_value("t4_imem_pc", imem_pc, 64'h100);
        step();
        check_value("t4_dec_pc", dec_pc, 64'h100);
        check_value("t4_count1", 64'(q_count), 64'd1);
        step();
        check_value("t4_dec_pc_next", dec_pc, 64'h108);

        // Branch in slot 1
        redirect_en = 1'b1;
        redirect_pc = 64'h2C;
        step();
        redirect_en = 1'b0;
        check_value("t5_imem_pc", imem_pc, 64'h2C);
        step();
        check_value("t5_dec_pc", dec_pc, 64'h2C);
        check_value("t5_instr1", 64'(dec_instr1), 64'h02728463);
`ifdef FETCH_BR_SPLIT_EN
        check_value("t5_valid2", 64'(dec_valid2), 64'd0);
        step();
        check_value("t5_next_pc", dec_pc, 64'h30);
        check_value("t5_next_valid2", 64'(dec_valid2), 64'd1);
`else
        check_value("t5_valid2", 64'(dec_valid2), 64'd1);
        step();
        check_value("t5_next_pc", dec_pc, 64'h34);
        check_value("t5_next_valid2", 64'(dec_valid2), 64'd1);
`endif

        // Reset beats a simultaneous redirect at count 3
        dec_ready   = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 64'h200;
        step();
        redirect_en = 1'b0;
        step();
        step();
        step();
        check_value("t6_count3", 64'(q_count), 64'd3);
        rst_n       = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 64'h300;
        step();
        rst_n       = 1'b1;
        redirect_en = 1'b0;
        check_value("t6_count", 64'(q_count), 64'd0);
        check_value("t6_valid", 64'(dec_valid), 64'd0);
        check_value("t6_imem_pc", imem_pc, 64'h0);
        step();
        check_value("t6_dec_pc", dec_pc, 64'h0);
        check_value("t6_instr1", 64'(dec_instr1), 64'h015A04B3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue_2way.md
Name: fetch_queue_2way

Overview:
- Two-wide instruction fetch unit for the 2-way superscalar core; drives the instruction memory's PC/PC4 read addresses and receives its two 32-bit words.
- Buffers fetched instruction pairs in a FIFO and presents them to decode with a valid/ready handshake.
- Handles branch redirect (flush plus new PC) from execute.
- Replaces the ad-hoc PC register previously used in the datapath.

Parameters:
- DEPTH, 4: queue entries (instruction pairs); power of two, ≥2.
- RESET_PC, 64'h0: fetch PC after reset.
- CNT_W, $clog2(DEPTH)+1: width of q_count.

Ports:
- clk  in  1  core clock, rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- redirect_en  in  1  branch taken / redirect request.
- redirect_pc  in  64  redirect target.
- imem_pc  out  64  instruction memory address, slot 1.
- imem_pc4  out  64  instruction memory address, slot 2.
- imem_instr1  in  32  word at imem_pc; combinational, valid same cycle.
- imem_instr2  in  32  word at imem_pc4; combinational, valid same cycle.
- dec_valid  out  1  head entry valid.
- dec_ready  in  1  decode accepts head entry.
- dec_pc  out  64  PC of head slot 1.
- dec_instr1  out  32  head slot-1 instruction.
- dec_instr2  out  32  head slot-2 instruction.
- dec_valid2  out  1  head slot 2 is valid.
- q_count  out  CNT_W  occupied entries.

Behaviour:
- Internal state: fetch_pc register, circular queue of {pc, instr1, instr2, v2}, rd_ptr/wr_ptr wrapping modulo DEPTH, count register.
- Address outputs (combinational): imem_pc = fetch_pc; imem_pc4 = fetch_pc + 4. Arithmetic is 64-bit, modulo 2^64.
- Pop: dec_valid && dec_ready.
- Push: redirect_en==0 && (count<DEPTH || pop).
  - Write {fetch_pc, imem_instr1, imem_instr2, v2=1} at wr_ptr.
  - fetch_pc <= fetch_pc + 8.
- No push: fetch_pc holds.
- Decode interface is first-word-fall-through:
  - dec_* reflect the entry at rd_ptr.
  - dec_valid = (count != 0).
  - When the queue is empty, dec_pc, dec_instr1, dec_instr2 and dec_valid2 drive 0.
- Latency: data present at imem_* in cycle N appears on dec_* in cycle N+1 if the queue was empty.
- Count update: push only → +1; pop only → −1; both → unchanged. With both at count==DEPTH, the queue stays full and no data is lost.
- Redirect, when redirect_en==1 at a rising edge:
  - rd_ptr = wr_ptr = count = 0.
  - fetch_pc <= {redirect_pc[63:2], 2'b00}.
  - No push that cycle. A simultaneous pop is discarded with no side effect; decode must ignore the head that cycle.
  - Next cycle: dec_valid=0 and imem_pc = new target.
- Reset, when rst_n==0 at a rising edge, regardless of other inputs including redirect:
  - fetch_pc=RESET_PC, pointers=0, count=0.
  - dec_valid=0, dec_valid2=0, dec_pc=0, dec_instr1=0, dec_instr2=0, q_count=0.
  - Reset mid-operation discards all queued entries.
- Full, no pop: imem_pc holds steady, so the same address is re-presented until space frees.

Optional Feature:
- Macro FETCH_BR_SPLIT_EN.
- Defined:
  - Predecode imem_instr1[6:0]. If it equals 7'h63 (branch) or 7'h67/7'h6F (jalr/jal), push with v2=0 and advance fetch_pc by 4 instead of 8.
  - The slot-2 word is then refetched as the next entry's slot 1, so no instruction after a control transfer issues in the same pair.
- Undefined: v2 is always 1, fetch_pc always advances by 8, and no predecode logic is present.

Test Plan:
1. Reset, then memory 0x0=32'h015A04B3, 0x4=32'h00148493, dec_ready=1 → first cycle after reset release imem_pc=0, imem_pc4=4. Next cycle dec_valid=1, dec_pc=0, dec_instr1=015A04B3, dec_instr2=00148493, dec_valid2=1. Then dec_pc steps 0x8, 0x10 each cycle.
2. DEPTH=4, dec_ready=0 from reset → q_count reaches 4 after 4 edges, imem_pc holds at 0x20. Then raise dec_ready with continuous fetch → q_count stays 4 and dec_pc increments 0,8,0x10,…
3. Queue full, redirect_en=1 with redirect_pc=0x56 → next cycle q_count=0, dec_valid=0, imem_pc=0x54. Following cycle dec_pc=0x54, dec_instr1=32'h014AEA13.
4. Simultaneous redirect and pop (dec_ready=1, count=2) → count=0, no stale entry ever reappears on dec_*.
5. FETCH_BR_SPLIT_EN defined, fetch at 0x2C (BEQ 32'h02728463) → entry dec_pc=0x2C, dec_valid2=0, next entry dec_pc=0x30. Macro undefined → dec_valid2=1, next dec_pc=0x34.
6. rst_n=0 for one edge while count=3 and redirect_en=1 → count=0, dec_valid=0, imem_pc=RESET_PC (redirect ignored).
